// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between the DSP chain and the I2S transmitter.
interface i2s_tx_if;
    logic [31:0] DIN_L;
    logic [31:0] DIN_R;
    logic        DIN_VALID;
    logic        DIN_READY;

    modport master (output DIN_L, output DIN_R, output DIN_VALID, input DIN_READY);
    modport slave  (input DIN_L, input DIN_R, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter, 64 BCLK per frame, 32 bits per channel, single ACLK domain.
// Optional build macro I2S_TX_HOLD_LAST_EN: repeat the last pair on underrun instead of silence.
module i2s_tx #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic     ACLK,
    input  logic     ARESETN,
    i2s_tx_if.slave  din,
    output logic     BCLK,
    output logic     LRCLK,
    output logic     SDOUT,
    output logic     FRAME_SYNC,
    output logic     UNDERRUN
);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_nxt;
    logic [63:0] frame;
    logic [63:0] frame_nxt;
    logic [63:0] hold;
    logic [63:0] din_word;
    logic        hold_valid;
    logic        tc;
    logic        fall;
    logic        load;
    logic        accept;
    logic        underrun_now;

    assign tc       = (div_cnt == DIV_LAST);
    assign fall     = tc & BCLK;
    assign load     = fall & (bit_cnt == 6'd63);
    assign bit_nxt  = bit_cnt + 6'd1;
    assign din_word = {din.DIN_L, din.DIN_R};

    assign din.DIN_READY = ~hold_valid | load;
    assign accept        = din.DIN_VALID & din.DIN_READY;

    // Frame source at load: held pair first, then a same-cycle bypass, else underrun.
    always_comb begin
        frame_nxt    = frame;
        underrun_now = 1'b0;
        if (load) begin
            if (hold_valid) begin
                frame_nxt = hold;
            end else if (accept) begin
                frame_nxt = din_word;
            end else begin
                underrun_now = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                frame_nxt = frame;
`else
                frame_nxt = '0;
`endif
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_cnt    <= '0;
            bit_cnt    <= 6'd63;
            frame      <= '0;
            BCLK       <= 1'b1;
            LRCLK      <= 1'b0;
            SDOUT      <= 1'b0;
            FRAME_SYNC <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            div_cnt    <= tc ? '0 : div_cnt + 8'd1;
            frame      <= frame_nxt;
            FRAME_SYNC <= load;
            UNDERRUN   <= underrun_now;
            if (tc) begin
                BCLK <= ~BCLK;
            end
            // Slot n carries W[63-n]; 63-n equals the bitwise inverse of a 6-bit n.
            if (fall) begin
                bit_cnt <= bit_nxt;
                SDOUT   <= frame_nxt[~bit_nxt];
                LRCLK   <= (bit_nxt >= 6'd31) && (bit_nxt <= 6'd62);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= hold_valid & accept;
        end else if (accept) begin
            hold_valid <= 1'b1;
        end
    end

    // A bypassed pair goes straight to the frame and never touches the holding register.
    always_ff @(posedge ACLK) begin
        if (accept && !(load && !hold_valid)) begin
            hold <= din_word;
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: BCLK_DIV=4 instance for framing/handshake/reset, BCLK_DIV=2 for the divider minimum.
module tb_i2s_tx;
    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;
`ifdef I2S_TX_HOLD_LAST_EN
    localparam logic [63:0] UN_EXP = 64'h1234_5678_9ABC_DEF0;
`else
    localparam logic [63:0] UN_EXP = 64'h0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    logic sel;
    logic [31:0] din_l;
    logic [31:0] din_r;
    logic din_valid;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic bclk4, lrclk4, sdout4, fs4, un4;
    logic bclk2, lrclk2, sdout2, fs2, un2;
    logic mbclk, mlr, msd, mfs, mun, mready;

    i2s_tx_if bus4 ();
    i2s_tx_if bus2 ();

    assign bus4.DIN_L     = din_l;
    assign bus4.DIN_R     = din_r;
    assign bus4.DIN_VALID = din_valid & ~sel;
    assign bus2.DIN_L     = din_l;
    assign bus2.DIN_R     = din_r;
    assign bus2.DIN_VALID = din_valid & sel;

    i2s_tx #(.BCLK_DIV(4)) dut4 (
        .ACLK(clk), .ARESETN(rst_n), .din(bus4),
        .BCLK(bclk4), .LRCLK(lrclk4), .SDOUT(sdout4), .FRAME_SYNC(fs4), .UNDERRUN(un4)
    );
    i2s_tx #(.BCLK_DIV(2)) dut2 (
        .ACLK(clk), .ARESETN(rst2_n), .din(bus2),
        .BCLK(bclk2), .LRCLK(lrclk2), .SDOUT(sdout2), .FRAME_SYNC(fs2), .UNDERRUN(un2)
    );

    assign mbclk  = sel ? bclk2  : bclk4;
    assign mlr    = sel ? lrclk2 : lrclk4;
    assign msd    = sel ? sdout2 : sdout4;
    assign mfs    = sel ? fs2    : fs4;
    assign mun    = sel ? un2    : un4;
    assign mready = sel ? bus2.DIN_READY : bus4.DIN_READY;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int un_cyc = 0, un_lone = 0, hi_len = 0, lo_len = 0, lr_int = 0, bt = 0, lt = 0;
    logic pb_m = 1'b1, plr_m = 1'b0;
    always @(negedge clk) begin
        if (mun) un_cyc <= un_cyc + 1;
        if (mun && !mfs) un_lone <= un_lone + 1;
        if (mbclk != pb_m) begin
            if (!mbclk) hi_len <= cyc - bt;
            else        lo_len <= cyc - bt;
            bt <= cyc;
        end
        pb_m <= mbclk;
        if (mlr != plr_m) begin
            lr_int <= cyc - lt;
            lt <= cyc;
        end
        plr_m <= mlr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r, output int t);
        int n;
        logic a;
        n = 0;
        a = 1'b0;
        t = -1;
        din_l = l;
        din_r = r;
        din_valid = 1'b1;
        do begin
            #1;
            a = mready;
            if (a) t = cyc;
            @(negedge clk);
            n++;
        end while (!a && n < 2000);
        din_valid = 1'b0;
        chk("send_accept", a, 1);
    endtask

    task automatic capture(output logic [63:0] data, output logic [63:0] lr,
                           output int wt, output int fs_at);
        int n;
        int rises;
        logic pb;
        data = '0;
        lr = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mfs && n < 4000);
        wt = n;
        fs_at = cyc;
        chk("cap_frame_sync", mfs, 1);
        pb = mbclk;
        rises = 0;
        n = 0;
        while (rises < 64 && n < 4000) begin
            @(negedge clk);
            n++;
            if (mbclk && !pb) begin
                data = {data[62:0], msd};
                lr   = {lr[62:0], mlr};
                rises++;
            end
            pb = mbclk;
        end
        chk("cap_bits", rises, 64);
    endtask

    logic [63:0] fr, lr, f1, f2, f3, f4, f5, f6, g1, g2, lr1, lr2, lrx;
    int ta, t1, t2, t3, tb_, tx, ty, wt, w1, w2, s0, s1, s2, sx, un_base, falls, n;
    logic pb;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        sel = 1'b0;
        din_valid = 1'b0;
        din_l = '0;
        din_r = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bclk", bclk4, 1);
        chk("rst_lrclk", lrclk4, 0);
        chk("rst_sdout", sdout4, 0);
        chk("rst_frame_sync", fs4, 0);
        chk("rst_underrun", un4, 0);
        chk("rst_ready", bus4.DIN_READY, 1);

        @(negedge clk);
        rst_n = 1'b1;
        fork
            send(32'h8000_0001, 32'hA5A5_5A5A, ta);
            capture(fr, lr, wt, s0);
        join
        #1;
        chk("basic_data", fr, 64'h8000_0001_A5A5_5A5A);
        chk("basic_lrclk", lr, LR_EXP);
        chk("basic_first_load", wt, 4);
        chk("basic_no_underrun", un_cyc, 0);

        fork
            begin
                send(32'hDEAD_BEEF, 32'h0123_4567, t1);
                send(32'hCAFE_F00D, 32'h89AB_CDEF, t2);
                send(32'h1234_5678, 32'h9ABC_DEF0, t3);
            end
            begin
                capture(f1, lrx, wt, s1);
                capture(f2, lrx, wt, s1);
                capture(f3, lrx, wt, s1);
            end
        join
        #1;
        chk("bp_frame1", f1, 64'hDEAD_BEEF_0123_4567);
        chk("bp_frame2", f2, 64'hCAFE_F00D_89AB_CDEF);
        chk("bp_frame3", f3, 64'h1234_5678_9ABC_DEF0);
        chk("bp_ready_wait_load", t2 - t1, 3);
        chk("bp_accept_period", t3 - t2, 512);
        chk("bp_no_underrun", un_cyc, 0);

        capture(f4, lrx, wt, s1);
        #1;
        chk("underrun_data", f4, UN_EXP);
        chk("underrun_one_cycle", un_cyc, 1);
        chk("underrun_with_fs", un_lone, 0);

        fork
            begin
                repeat (3) @(negedge clk);
                send(32'h5555_AAAA, 32'h0F0F_F0F0, tb_);
                #1;
                chk("bypass_ready", mready, 1);
            end
            capture(f5, lrx, wt, s1);
        join
        #1;
        chk("bypass_data", f5, 64'h5555_AAAA_0F0F_F0F0);
        chk("bypass_no_underrun", un_cyc, 1);

        send(32'h7777_0000, 32'h00FF_7777, tx);
        send(32'hFFFF_0000, 32'h0000_FFFF, ty);
        pb = mbclk;
        falls = 0;
        n = 0;
        while (falls < 40 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pb && !mbclk) falls++;
            pb = mbclk;
        end
        #2;
        chk("rst_pre_ready", mready, 0);
        chk("rst_pre_lrclk", mlr, 1);
        chk("rst_pre_sdout", msd, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_bclk", bclk4, 1);
        chk("arst_lrclk", lrclk4, 0);
        chk("arst_sdout", sdout4, 0);
        chk("arst_frame_sync", fs4, 0);
        chk("arst_underrun", un4, 0);
        chk("arst_ready", bus4.DIN_READY, 1);
        un_base = un_cyc;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        capture(f6, lrx, wt, sx);
        #1;
        chk("arst_discard_data", f6, 0);
        chk("arst_first_load", wt, 4);
        chk("arst_underrun", un_cyc - un_base, 1);

        sel = 1'b1;
        @(negedge clk);
        rst2_n = 1'b1;
        fork
            begin
                send(32'hC001_D00D, 32'h2468_ACE0, ta);
                send(32'h1357_9BDF, 32'hFEDC_BA98, ta);
            end
            begin
                capture(g1, lr1, w1, s1);
                capture(g2, lr2, w2, s2);
            end
        join
        #1;
        chk("div2_frame1", g1, 64'hC001_D00D_2468_ACE0);
        chk("div2_frame2", g2, 64'h1357_9BDF_FEDC_BA98);
        chk("div2_lrclk", lr2, LR_EXP);
        chk("div2_first_load", w1, 2);
        chk("div2_frame_period", s2 - s1, 256);
        chk("div2_bclk_high", hi_len, 2);
        chk("div2_bclk_low", lo_len, 2);
        chk("div2_lrclk_edge", lr_int, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S transmitter: accepts parallel 32-bit left/right sample pairs over a valid/ready handshake and serialises them as a standard Philips I2S stream (BCLK, LRCLK, SDOUT). It runs entirely in the ACLK domain and is the transmit counterpart of `i2s_rx`. It drives the codec or loopback path from the DSP chain and shares `i2s_rx`'s frame format: 64 BCLK per frame, 32 bits per channel.

## Interface
- BCLK_DIV, 4, ACLK cycles per BCLK half-period; legal range 2..255.
- ACLK  in  1  system clock; all logic on its rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- DIN_L  in  32  left sample, MSB first on the wire.
- DIN_R  in  32  right sample.
- DIN_VALID  in  1  sample pair valid.
- DIN_READY  out  1  holding register empty or being emptied this cycle.
- BCLK  out  1  bit clock, registered.
- LRCLK  out  1  word select; 0 = left, 1 = right; registered.
- SDOUT  out  1  serial data, registered.
- FRAME_SYNC  out  1  one-cycle pulse on every frame load.
- UNDERRUN  out  1  one-cycle pulse when a frame load finds no sample.

## Operation
- Divider: `div_cnt` counts 0..BCLK_DIV-1 and wraps. At terminal count (tc), BCLK toggles.
  - Fall event = tc while BCLK=1.
  - Rise event = tc while BCLK=0.
- Bit counter `bit_cnt` (6 bit) increments on each fall event and wraps 63→0.
- Frame word W = {L[31:0], R[31:0]}. In slot n, SDOUT = W[63-n].
- LRCLK = 1 for n = 31..62; LRCLK = 0 for n = 63 and 0..30.
  - Left MSB follows the LRCLK fall by one BCLK; right MSB follows the LRCLK rise by one BCLK (Philips I2S).
- Holding register: `hold` (64 bit) plus `hold_valid`.
  - DIN_READY = ~hold_valid | load.
  - Accept = DIN_VALID & DIN_READY.
- Frame load happens on the fall event where bit_cnt 63→0:
  - If hold_valid: W ← hold, hold_valid ← 0.
  - Else if accept in the same cycle: bypass, W ← {DIN_L, DIN_R}, nothing written to hold. No underrun.
  - Else: underrun. UNDERRUN = 1 for that cycle; W per Configuration.
  - FRAME_SYNC = 1 on every load cycle.
- Accept coinciding with a load that drains a valid hold writes the new pair into hold; hold_valid stays 1.
- Reset values:
  - Outputs: BCLK=1, LRCLK=0, SDOUT=0, FRAME_SYNC=0, UNDERRUN=0, DIN_READY=1.
  - Internal state: div_cnt=0, bit_cnt=63, W=0, hold_valid=0.
- Reset asserted mid-frame: all state returns to reset values asynchronously. A held pair and the frame in flight are discarded. After release, the first load occurs at the first fall event (BCLK_DIV cycles).

## Timing
- BCLK period = 2·BCLK_DIV ACLK cycles. Frame = 128·BCLK_DIV cycles (512 at default).
- LRCLK, SDOUT, FRAME_SYNC and UNDERRUN update in the same ACLK cycle that BCLK falls. They are stable for BCLK_DIV cycles before the rise, where the receiver samples.
- Latency: a pair accepted at or before a load cycle has its first bit on SDOUT in that load cycle (bypass) or in the next load cycle (from hold). Worst case 2 frames.
- Throughput: one pair per frame. DIN_READY deasserts the cycle after an accept into an empty hold and reasserts on the next load cycle.

## Configuration
- I2S_TX_HOLD_LAST_EN
  - Defined: on underrun, W keeps the previously transmitted pair, so the last sample repeats.
  - Undefined: on underrun, W ← 64'h0 (silence).
  - UNDERRUN pulses in both builds.

## Test plan
- Basic frame: reset, BCLK_DIV=4, present L=32'h8000_0001, R=32'hA5A5_5A5A before the first load.
  - Bits sampled on BCLK rise: left reads 8000_0001 while LRCLK=0, right reads A5A5_5A5A while LRCLK=1.
  - LRCLK falls one BCLK before the left MSB. UNDERRUN never asserts.
- Back-pressure: DIN_VALID held high with three distinct pairs.
  - First pair bypasses or fills hold. DIN_READY=0 until the next load; exactly one accept per 512 cycles.
  - Frames carry the pairs in order.
- Underrun: stop feeding after pair 0x1234_5678/0x9ABC_DEF0.
  - UNDERRUN is a single-cycle pulse coincident with FRAME_SYNC.
  - SDOUT is all zeros, or repeats 1234_5678/9ABC_DEF0 with I2S_TX_HOLD_LAST_EN.
- Bypass: DIN_VALID first asserted exactly on the load cycle with hold empty.
  - The pair is transmitted in that frame. No UNDERRUN. DIN_READY stays 1.
- Reset mid-frame: ARESETN low at bit_cnt=40 with hold full.
  - Outputs go to reset values without waiting for an ACLK edge.
  - After release, the first frame is an underrun (held pair discarded).
- Divider minimum: BCLK_DIV=2.
  - BCLK high/low 2 cycles each; frame 256 cycles.
  - LRCLK edges every 128 cycles; data correct.
